ofmap_writer: RTL

Output-side counterpart of the convolution feeder: accepts the result stream produced from the feeder's windows and writes it into an internal output-feature-map RAM. Results arrive pixel-major with channels innermost. Once the expected word count is stored, the block reports full. On a drain request it streams the map back out channel-planar (batch, channel, row, col) with a last flag, ready for the next layer's input RAM loader.

---
 rtl/ofmap_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ofmap_writer.sv
// ofmap_writer: captures a pixel-major result stream into RAM and drains it channel-planar (OFMAP_RELU_EN: zero negative words at capture)
module ofmap_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] o_dimension,
    input  logic [ADDR_WIDTH-1:0] chans_per_mem,
    input  logic [ADDR_WIDTH-1:0] batch_size,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_full,
    input  logic                  drain_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  cfg_err,
    output logic [1:0]            state
);
    localparam int W  = 2 * ADDR_WIDTH;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, FULL = 2'd2, READ = 2'd3;

    logic [1:0]            nxt;
    logic [W-1:0]          o_r, c_r, b_r, total, total_in, wr_ptr, rd_addr;
    logic [W-1:0]          cnt_b, cnt_ch, cnt_r, cnt_c;
    logic                  issuing, cfg_ok, wr_fire, wr_last;
    logic                  c_max, r_max, ch_max, b_max, rd_final;
    logic                  unused_hi;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    assign total_in = W'(o_dimension) * W'(chans_per_mem) * W'(o_dimension) * W'(batch_size);
    assign cfg_ok   = total_in != '0 && total_in <= W'(DEPTH);
    assign wr_fire  = state == WRITE && in_valid;
    assign wr_last  = wr_ptr == total - W'(1);
    assign c_max    = cnt_c == o_r - W'(1);
    assign r_max    = cnt_r == o_r - W'(1);
    assign ch_max   = cnt_ch == c_r - W'(1);
    assign b_max    = cnt_b == b_r - W'(1);
    assign rd_final = issuing && c_max && r_max && ch_max && b_max;
    assign rd_addr  = ((cnt_b * o_r + cnt_r) * o_r + cnt_c) * c_r + cnt_ch;
    assign unused_hi = ^{rd_addr[W-1:IW], wr_ptr[W-1:IW]};

`ifdef OFMAP_RELU_EN
    assign wdata = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign wdata = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start && cfg_ok ? WRITE : IDLE;
            WRITE:   nxt = wr_fire && wr_last ? FULL : WRITE;
            FULL:    nxt = drain_en ? READ : FULL;
            default: nxt = out_last ? IDLE : READ;
        endcase
    end

    always_comb begin
        in_ready = state == WRITE;
        ram_full = state == FULL || state == READ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_r       <= '0;
            c_r       <= '0;
            b_r       <= '0;
            total     <= '0;
            wr_ptr    <= '0;
            cnt_b     <= '0;
            cnt_ch    <= '0;
            cnt_r     <= '0;
            cnt_c     <= '0;
            issuing   <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                o_r     <= W'(o_dimension);
                c_r     <= W'(chans_per_mem);
                b_r     <= W'(batch_size);
                total   <= total_in;
                cfg_err <= !cfg_ok;
                wr_ptr  <= '0;
            end
            if (wr_fire) wr_ptr <= wr_ptr + W'(1);
            // Column is innermost, then row, then channel, then batch.
            if (state == FULL && drain_en) begin
                issuing <= 1'b1;
                cnt_b   <= '0;
                cnt_ch  <= '0;
                cnt_r   <= '0;
                cnt_c   <= '0;
            end else if (issuing) begin
                issuing <= !rd_final;
                cnt_c   <= c_max ? '0 : cnt_c + W'(1);
                cnt_r   <= c_max ? (r_max ? '0 : cnt_r + W'(1)) : cnt_r;
                cnt_ch  <= c_max && r_max ? (ch_max ? '0 : cnt_ch + W'(1)) : cnt_ch;
                cnt_b   <= c_max && r_max && ch_max ? cnt_b + W'(1) : cnt_b;
            end
            out_valid <= issuing;
            out_last  <= rd_final;
            if (issuing) out_data <= ram[rd_addr[IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) ram[wr_ptr[IW-1:0]] <= wdata;
    end
endmodule
